// File: rtl/controller_pkg.sv
// Shared types and constants for the Genius memory game controller.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GENERATE,
        SHOW_SEQUENCE,
        GET_PLAYER_INPUT,
        FEEDBACK,
        VICTORY,
        DEFEAT
    } state_t;

    localparam int FEEDBACK_CYCLES = 8;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [5:0] seq_len(input logic [1:0] lvl);
        logic [5:0] n;
        unique case (lvl)
            2'b00:   n = 6'd8;
            2'b01:   n = 6'd16;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lfsr_prng.sv
// Free-running 16-bit LFSR; the two LSBs give the next colour.
module lfsr_prng
    import controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] random_out
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign random_out = lfsr[1:0];

endmodule

// File: rtl/controller.sv
// Genius (Simon) game controller: sequence generation, playback,
// player checking and victory/defeat handling.
module controller
    import controller_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_button,
    input  logic [3:0] player_input,
    input  logic       speed_game,
    input  logic [1:0] difficulty_level,
    input  logic       game_mode,
    output logic [3:0] leds_sequence,
    output logic       game_active,
    output logic [7:0] score_display,
    output logic [1:0] random_out
);

    localparam logic [31:0] T_SLOW = 32'(2 * CLK_FREQ);
    localparam logic [31:0] T_FAST = 32'(CLK_FREQ / 2);

    state_t current_state, next_state;

    logic [127:0] sequence_reg;
    logic [5:0]   sequence_index;
    logic [5:0]   seq_n;
    logic [5:0]   round_len;
    logic         speed_q;
    logic [31:0]  timer;
    logic [31:0]  t_on;
    logic [31:0]  t_off;
    logic         show_off;
    logic [2:0]   fb_cnt;
    logic [3:0]   fb_value;
    logic [3:0]   input_prev;
    logic [3:0]   cur_elem;
    logic         start_prev;
    logic         get_first;
    logic         start_edge;
    logic         press_event;
    logic         press_ok;
    logic         gen_last;
    logic         show_last;
    logic         on_end;
    logic         elem_end;
    logic         fb_done;
    logic [1:0]   rnd;

    lfsr_prng u_prng (
        .clk       (clk),
        .rst_n     (rst_n),
        .random_out(rnd)
    );

    assign random_out = rnd;

    always_comb begin
        t_on        = speed_q ? T_FAST : T_SLOW;
        t_off       = t_on >> 2;
        start_edge  = start_button & ~start_prev;
        cur_elem    = sequence_reg[{sequence_index[4:0], 2'b00} +: 4];
        gen_last    = (sequence_index == seq_n - 6'd1);
        show_last   = (sequence_index == round_len - 6'd1);
        on_end      = !show_off && (timer == t_on - 32'd1);
        elem_end    = show_off && (timer == t_off - 32'd1);
        fb_done     = (fb_cnt == 3'(FEEDBACK_CYCLES - 1));
        // The first GET cycle only captures the baseline
        press_event = (current_state == GET_PLAYER_INPUT) && !get_first &&
                      (player_input != 4'h0) &&
                      (player_input != input_prev);
        press_ok    = (player_input == cur_elem);
    end

    always_comb begin
        next_state    = current_state;
        leds_sequence = 4'h0;
        game_active   = 1'b0;
        unique case (current_state)
            IDLE, VICTORY, DEFEAT: begin
                if (current_state == VICTORY) leds_sequence = 4'hF;
                if (start_edge) next_state = GENERATE;
            end
            GENERATE: begin
                game_active = 1'b1;
                if (gen_last) next_state = SHOW_SEQUENCE;
            end
            SHOW_SEQUENCE: begin
                game_active = 1'b1;
                if (!show_off) leds_sequence = cur_elem;
                if (elem_end && show_last) next_state = GET_PLAYER_INPUT;
            end
            GET_PLAYER_INPUT: begin
                game_active = 1'b1;
                if (press_event) next_state = press_ok ? FEEDBACK : DEFEAT;
            end
            FEEDBACK: begin
                game_active   = 1'b1;
                leds_sequence = fb_value;
                if (fb_done) begin
                    if (sequence_index < round_len) next_state = GET_PLAYER_INPUT;
                    else if (round_len == seq_n)    next_state = VICTORY;
                    else                            next_state = SHOW_SEQUENCE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) current_state <= IDLE;
        else        current_state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sequence_reg   <= '0;
            sequence_index <= '0;
            seq_n          <= 6'd8;
            round_len      <= 6'd8;
            speed_q        <= 1'b0;
            timer          <= '0;
            show_off       <= 1'b0;
            fb_cnt         <= '0;
            fb_value       <= '0;
            input_prev     <= '0;
            start_prev     <= 1'b0;
            get_first      <= 1'b0;
            score_display  <= '0;
        end else begin
            start_prev <= start_button;
            input_prev <= player_input;
            unique case (current_state)
                IDLE, VICTORY, DEFEAT: begin
                    if (start_edge) begin
                        seq_n          <= seq_len(difficulty_level);
                        round_len      <= game_mode ? 6'd1 : seq_len(difficulty_level);
                        speed_q        <= speed_game;
                        score_display  <= '0;
                        sequence_index <= '0;
                        sequence_reg   <= '0;
                    end
                end
                GENERATE: begin
                    sequence_reg[{sequence_index[4:0], 2'b00} +: 4] <= 4'b0001 << rnd;
                    if (gen_last) begin
                        sequence_index <= '0;
                        timer          <= '0;
                        show_off       <= 1'b0;
                    end else begin
                        sequence_index <= sequence_index + 6'd1;
                    end
                end
                SHOW_SEQUENCE: begin
                    if (on_end) begin
                        timer    <= '0;
                        show_off <= 1'b1;
                    end else if (elem_end) begin
                        timer    <= '0;
                        show_off <= 1'b0;
                        if (show_last) begin
                            sequence_index <= '0;
                            get_first      <= 1'b1;
                        end else begin
                            sequence_index <= sequence_index + 6'd1;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                GET_PLAYER_INPUT: begin
                    get_first <= 1'b0;
                    if (press_event && press_ok) begin
                        if (score_display != 8'hFF) score_display <= score_display + 8'd1;
                        sequence_index <= sequence_index + 6'd1;
                        fb_value       <= player_input;
                        fb_cnt         <= '0;
                    end
                end
                FEEDBACK: begin
                    fb_cnt <= fb_cnt + 3'd1;
                    if (fb_done) begin
                        if (sequence_index < round_len) begin
                            get_first <= 1'b1;
                        end else if (round_len != seq_n) begin
                            round_len      <= round_len + 6'd1;
                            sequence_index <= '0;
                            timer          <= '0;
                            show_off       <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for the Genius controller: plays whole games
// against a player model and checks timing, scoring and end states.
module tb_controller;

    localparam int CF = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_button = 1'b0;
    logic [3:0] player_input = 4'h0;
    logic       speed_game = 1'b0;
    logic [1:0] difficulty_level = 2'b00;
    logic       game_mode = 1'b0;
    logic [3:0] leds_sequence;
    logic       game_active;
    logic [7:0] score_display;
    logic [1:0] random_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] idle_val = 4'b0101;

    controller #(.CLK_FREQ(CF)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_button    (start_button),
        .player_input    (player_input),
        .speed_game      (speed_game),
        .difficulty_level(difficulty_level),
        .game_mode       (game_mode),
        .leds_sequence   (leds_sequence),
        .game_active     (game_active),
        .score_display   (score_display),
        .random_out      (random_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic play(input bit mode, input logic [1:0] diff, input bit spd,
                        input int fail_at, input logic [3:0] wrong_fixed,
                        input int exp_shown, input int exp_score);
        int n, len, t_on, t_off, g, d, shown, answered, score_m;
        logic [3:0] seq[$];
        logic [3:0] v, ans;
        bit wrong, lost, done, timeout;
        n = (diff == 2'b00) ? 8 : (diff == 2'b01) ? 16 : 32;
        t_on = spd ? CF / 2 : 2 * CF;
        t_off = t_on / 4;
        len = mode ? 1 : n;
        shown = 0; answered = 0; score_m = 0;
        lost = 0; done = 0; timeout = 0; wrong = 0;
        game_mode = mode; difficulty_level = diff; speed_game = spd;
        @(negedge clk); start_button = 1'b1;
        @(negedge clk); start_button = 1'b0;
        speed_game = ~spd;
        difficulty_level = ~diff;
        n_cmp++;
        if (game_active !== 1'b1) begin
            n_bad++; $display("FAIL start_active: got %b want 1", game_active);
        end
        g = 0;
        while (leds_sequence === 4'h0 && g < 200) begin g++; @(negedge clk); end
        n_cmp++;
        if (g !== n) begin
            n_bad++; $display("FAIL gen_len: got %0d want %0d", g, n);
        end
        while (!done && !timeout) begin
            for (int e = 0; e < len; e++) begin
                d = 0;
                while (leds_sequence === 4'h0 && d < 2 * t_on) begin d++; @(negedge clk); end
                if (leds_sequence === 4'h0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL show_timeout: got leds 0 want lit element %0d", e);
                    timeout = 1;
                    break;
                end
                if (e == 1) begin
                    n_cmp++;
                    if (d !== t_off) begin
                        n_bad++; $display("FAIL off_time: got %0d want %0d", d, t_off);
                    end
                end
                v = leds_sequence;
                d = 0;
                while (leds_sequence === v && d <= t_on) begin d++; @(negedge clk); end
                if (e == 0) begin
                    n_cmp++;
                    if (d !== t_on) begin
                        n_bad++; $display("FAIL on_time: got %0d want %0d", d, t_on);
                    end
                end
                n_cmp++;
                if ($countones(v) != 1) begin
                    n_bad++; $display("FAIL onehot: got %b want one-hot", v);
                end
                if (e < seq.size()) begin
                    n_cmp++;
                    if (v !== seq[e]) begin
                        n_bad++; $display("FAIL replay: got %b want %b", v, seq[e]);
                    end
                end else begin
                    seq.push_back(v);
                end
                shown++;
            end
            if (timeout) break;
            repeat (t_off + 2) @(negedge clk);
            for (int i = 0; i < len; i++) begin
                wrong = (answered == fail_at);
                ans = seq[i];
                if (wrong) begin
                    ans = wrong_fixed;
                    while (ans == 4'h0 || ans == seq[i]) ans = 4'($urandom_range(1, 15));
                end
                player_input = ans;
                @(negedge clk);
                if (wrong) begin
                    n_cmp++;
                    if (game_active !== 1'b0 || leds_sequence !== 4'h0) begin
                        n_bad++;
                        $display("FAIL defeat_state: got active %b leds %b want 0 0000",
                                 game_active, leds_sequence);
                    end
                    lost = 1;
                    player_input = idle_val;
                    break;
                end
                score_m++;
                answered++;
                n_cmp++;
                if (leds_sequence !== ans) begin
                    n_bad++; $display("FAIL fb_leds: got %b want %b", leds_sequence, ans);
                end
                n_cmp++;
                if (score_display !== 8'(score_m)) begin
                    n_bad++; $display("FAIL score_step: got %0d want %0d", score_display, score_m);
                end
                @(negedge clk);
                player_input = idle_val;
                repeat ((i == len - 1) ? 7 : 9) @(negedge clk);
            end
            if (lost) break;
            if (mode && len < n) len++;
            else done = 1;
        end
        if (!lost && !timeout) begin
            n_cmp++;
            if (leds_sequence !== 4'hF || game_active !== 1'b0) begin
                n_bad++;
                $display("FAIL victory_state: got leds %b active %b want 1111 0",
                         leds_sequence, game_active);
            end
        end
        n_cmp++;
        if (score_display !== 8'(exp_score)) begin
            n_bad++; $display("FAIL final_score: got %0d want %0d", score_display, exp_score);
        end
        n_cmp++;
        if (shown !== exp_shown) begin
            n_bad++; $display("FAIL shown_count: got %0d want %0d", shown, exp_shown);
        end
        player_input = idle_val;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (leds_sequence !== 4'h0 || game_active !== 1'b0 || score_display !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got leds %b active %b score %0d want 0 0 0",
                     leds_sequence, game_active, score_display);
        end
        n_cmp++;
        if (random_out !== 2'b01) begin
            n_bad++; $display("FAIL reset_prng: got %b want 01", random_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_prng();
        logic [3:0] seen;
        seen = 4'h0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            seen[random_out] = 1'b1;
        end
        n_cmp++;
        if (seen !== 4'hF) begin
            n_bad++; $display("FAIL prng_values: got %b want 1111", seen);
        end
    endtask

    task automatic test_victory_slow();
        play(1'b0, 2'b00, 1'b0, -1, 4'h0, 8, 8);
    endtask

    task automatic test_defeat_fixed();
        play(1'b0, 2'b00, 1'b1, 0, 4'hF, 8, 0);
    endtask

    task automatic test_long();
        play(1'b0, 2'b01, 1'b1, -1, 4'h0, 16, 16);
    endtask

    task automatic test_defeat_random();
        int k;
        k = int'($urandom_range(1, 7));
        play(1'b0, 2'b00, 1'b1, k, 4'h0, 8, k);
    endtask

    task automatic test_rounds();
        play(1'b1, 2'b00, 1'b1, -1, 4'h0, 36, 36);
    endtask

    task automatic test_reset_mid();
        int g;
        logic [3:0] v;
        game_mode = 1'b0; difficulty_level = 2'b00; speed_game = 1'b1;
        @(negedge clk); start_button = 1'b1;
        @(negedge clk); start_button = 1'b0;
        g = 0;
        while (leds_sequence === 4'h0 && g < 100) begin g++; @(negedge clk); end
        v = leds_sequence;
        start_button = 1'b1;
        @(negedge clk); start_button = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (leds_sequence !== v || game_active !== 1'b1 || v === 4'h0) begin
            n_bad++;
            $display("FAIL start_ignored: got leds %b active %b want %b 1",
                     leds_sequence, game_active, v);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (leds_sequence !== 4'h0 || game_active !== 1'b0 || score_display !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got leds %b active %b score %0d want 0 0 0",
                     leds_sequence, game_active, score_display);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_prng();
        test_victory_slow();
        test_defeat_fixed();
        test_long();
        test_defeat_random();
        test_reset_mid();
        test_rounds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/controller.md
# controller

Top-level game controller for the Genius (Simon) memory game. On a start press it generates a random colour sequence, plays it on four LEDs, checks the player's button entries element by element, and ends in victory or defeat. It sits between the board buttons/switches and the LED/score display logic and contains its own pseudo-random generator.

## Interface
- CLK_FREQ, default 50_000_000: clock cycles per second; all display durations derive from it.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- start_button  in  1  start request, active high; rising edge (0→1) triggers.
- player_input  in  4  player buttons, one bit per colour.
- speed_game  in  1  0 = slow (element shown 2 s), 1 = fast (0.5 s).
- difficulty_level  in  2  sequence length N: 00→8, 01→16, 10→32, 11→32.
- game_mode  in  1  0 = full sequence per game, 1 = growing rounds.
- leds_sequence  out  4  colour LEDs, one-hot while showing.
- game_active  out  1  high while a game is in progress.
- score_display  out  8  count of correct entries in the current game.
- random_out  out  2  current PRNG colour bits.

## Operation
- States, enum `current_state`: IDLE, GENERATE, SHOW_SEQUENCE, GET_PLAYER_INPUT, FEEDBACK, VICTORY, DEFEAT.
- Required internal names: `current_state`; `sequence_reg` [127:0], element i at [i*4 +: 4], one-hot; `sequence_index` [5:0].
- IDLE/VICTORY/DEFEAT: start edge → GENERATE; latch difficulty_level, game_mode, speed_game; clear score; round length L = 1 in mode 1, L = N in mode 0.
- GENERATE: one element per cycle for N cycles: 2-bit PRNG value v → one-hot (1<<v) into sequence_reg; then SHOW_SEQUENCE, sequence_index = 0.
- SHOW_SEQUENCE: element sequence_index on leds for T_on, LEDs off for T_on/4, index++; after L elements → GET_PLAYER_INPUT, index = 0.
- T_on = 2·CLK_FREQ cycles (slow), CLK_FREQ/2 (fast).
- GET_PLAYER_INPUT: baseline = player_input value on entry; a press event is a cycle where player_input is nonzero and differs from previous-cycle value. Event equal to sequence_reg[index] → score++, index++, FEEDBACK; otherwise → DEFEAT.
- FEEDBACK: 8 cycles, leds show accepted element, input ignored. Then: index < L → GET_PLAYER_INPUT (new baseline); index = L and L = N → VICTORY; index = L, L < N (mode 1) → L++, index = 0, SHOW_SEQUENCE.
- leds_sequence: 0000 in IDLE, GENERATE, GET_PLAYER_INPUT, DEFEAT; 1111 in VICTORY.
- game_active = 1 in GENERATE through FEEDBACK; 0 otherwise.
- score_display saturates at 255; held through VICTORY/DEFEAT until next start.
- PRNG: 16-bit maximal LFSR, seed 16'hACE1, free-running every cycle; random_out = its two LSBs.

## Timing
- Reset: state IDLE, all outputs 0, sequence_reg 0, index 0, LFSR = seed.
- Start edge registered; GENERATE entered next cycle; SHOW_SEQUENCE after N further cycles.
- Press event detected in the cycle it appears; DEFEAT or FEEDBACK is the state in the following cycle (≤2 cycles from input change).
- Start edges ignored while game_active; input changes outside GET_PLAYER_INPUT never count.
- Reset mid-game aborts immediately to IDLE.

## Structure
- Package `controller_pkg`: state enum, difficulty→N function, FEEDBACK length, LFSR seed/taps.
- Sub-module `lfsr_prng` (16-bit LFSR, 2-bit output); FSM, timers and sequence store in controller.

## Test plan
- CLK_FREQ=200, slow, difficulty 00, mode 0: start, answer each GET with sequence_reg[index] (held 2 cycles then 0101) → VICTORY after 8th answer, score 8, leds 1111.
- From VICTORY, start, first answer 1111 → DEFEAT within 2 cycles, game_active 0.
- Difficulty 01, mode 0, correct answers → exactly 16 elements shown, index never >15, VICTORY with score 16.
- Mode 1, difficulty 00, correct answers → rounds of 1..8 shown, VICTORY, score 36.
- speed 1 → each element lit 100 cycles with CLK_FREQ=200; speed 0 → 400 cycles.
- Assert rst_n low during SHOW_SEQUENCE → IDLE, outputs 0 immediately; start while active ignored.
